return_addr_stack_ckpt: RTL and testbench
=========================================

Name: return_addr_stack_ckpt

Overview:
Return-address stack for the frontend branch predictor.
- Sits beside the BHT/BTB and feeds predicted return targets to the fetch-address select stage.
- Calls push the link address; returns pop it to predict the target.
- Optional checkpoint/restore repairs the stack pointer after a mispredicted speculative call/return.
- Depth comes from the core configuration RAS depth (2 on the 32-bit FPGA configuration).

Parameters:
DEPTH, 2, number of stack entries (≥2, power of two not required)
XLEN, 32, address width
CW, $clog2(DEPTH+1), width of count_o (derived, not overridable)

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  empty the stack (fence.i / pipeline flush)
push_i  in  1  call detected; push addr_i
pop_i  in  1  return detected; pop top entry
addr_i  in  XLEN  return address to push (PC of call + 4)
top_o  out  XLEN  current top-of-stack address (predicted return target)
top_valid_o  out  1  stack non-empty, top_o meaningful
count_o  out  CW  number of valid entries, 0..DEPTH
ovf_o  out  1  one-cycle pulse: previous cycle's push overwrote the oldest entry
ckpt_i  in  1  snapshot pointer and count (speculative branch issued)
restore_i  in  1  restore snapshot (branch mispredict resolved)

Behaviour:
- Reset (async, rst_ni=0):
  - entries=0, tos pointer=0, count=0.
  - ovf_o=0, top_o=0, top_valid_o=0, snapshot pointer and count=0.
- Storage: circular buffer of DEPTH entries; tos indexes the current top entry. All updates occur on the rising clk_i edge.
- Outputs:
  - top_o = entry[tos] when count>0, else 0 (combinational from registers; zero-latency read).
  - top_valid_o = (count!=0).
  - count_o = count.
- Priority per cycle: flush_i > restore_i > push/pop. ckpt_i is independent.
- flush_i: count←0, tos←0. Entries are left unchanged (unobservable). Push/pop in the same cycle are ignored.
- push only:
  - tos←(tos+1) mod DEPTH; entry[new tos]←addr_i.
  - If count<DEPTH, count+1.
  - If count==DEPTH, count stays DEPTH, the oldest entry is overwritten, and ovf_o=1 next cycle.
- pop only:
  - If count>0: tos←(tos−1) mod DEPTH (wraps from 0 to DEPTH−1), count−1.
  - If count==0: no state change (underflow ignored, no error).
- push and pop together (return-then-call / tail call):
  - entry[tos]←addr_i; tos and count unchanged.
  - If count==0, treat as push only (count←1).
- ovf_o: registered; high for exactly one cycle after an overwriting push, otherwise 0.
- Modulo arithmetic: DEPTH need not be a power of two; wrap is an explicit compare, not bit truncation.
- Reset asserted mid-operation returns everything to reset values immediately; no partial state survives.

Optional Feature:
Macro: RAS_CKPT_EN
- Defined:
  - ckpt_i=1 captures {tos, count} as seen after this cycle's push/pop update.
  - restore_i=1 loads tos and count from the snapshot; push/pop in that cycle are ignored. Entry contents are not restored; entries overwritten since the checkpoint remain overwritten (accepted prediction inaccuracy).
  - ckpt_i and restore_i in the same cycle: restore wins, and the snapshot is re-captured with the restored values.
  - flush_i also clears the snapshot to {0,0}.
- Not defined:
  - ckpt_i and restore_i are ignored; no snapshot registers exist.
  - The ports remain present for interface stability.

Test Plan:
1. Overflow (DEPTH=2): push 0x100, push 0x200, push 0x300 -> count_o=2, top_o=0x300, ovf_o=1 for exactly the cycle after the third push; pop -> top_o=0x200; pop -> count_o=0, top_valid_o=0, top_o=0 (0x100 lost).
2. Underflow: from reset, pop for 3 cycles -> count_o=0, top_valid_o=0, no X on outputs; then push 0x44 -> top_o=0x44, count_o=1.
3. Simultaneous push/pop:
   - With stack {0x10,0x20(top)}, push+pop addr 0x30 -> count_o=2, top_o=0x30; pop -> top_o=0x10.
   - On an empty stack, push+pop addr 0x50 -> count_o=1, top_o=0x50.
4. Flush priority: stack holds 2 entries; flush_i with push_i of 0x99 in the same cycle -> count_o=0, top_valid_o=0; a subsequent push of 0x60 -> top_o=0x60, count_o=1.
5. Checkpoint (RAS_CKPT_EN):
   - Push 0xA0, ckpt_i, push 0xB0, pop, pop, restore_i -> count_o=1, top_o=0xA0.
   - Repeat without the macro -> restore ignored, count_o=0.
6. Reset mid-operation: assert rst_ni=0 asynchronously between edges while count_o=2 -> all outputs 0 immediately; after release, the first push of 0x70 gives count_o=1, top_o=0x70, ovf_o=0.

Source files
------------

// File: rtl/return_addr_stack_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : return_addr_stack_ckpt
// Brief    : Return-address stack for the frontend branch predictor. Calls
//            push the link address, returns pop it, and the top entry is
//            presented combinationally as the predicted return target.
//            Circular buffer of DEPTH entries; overflow overwrites the oldest.
// Option   : RAS_CKPT_EN - adds a {tos, count} snapshot that ckpt_i captures
//            and restore_i reloads, to repair the pointer after a mispredict.
//            Without it ckpt_i/restore_i are accepted but ignored.
// Revision : 1.0 - initial release
// ============================================================================
module return_addr_stack_ckpt #(
  parameter  int DEPTH = 2,
  parameter  int XLEN  = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] addr_i,
  output logic [XLEN-1:0] top_o,
  output logic            top_valid_o,
  output logic [CW-1:0]   count_o,
  output logic            ovf_o,
  input  logic            ckpt_i,
  input  logic            restore_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] entries [DEPTH];
  logic [PW-1:0]   tos;
  logic [CW-1:0]   count;
  logic            ovf;

  logic [PW-1:0]   tos_nxt;
  logic [CW-1:0]   count_nxt;
  logic            ovf_nxt;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [PW-1:0]   tos_inc;
  logic [PW-1:0]   tos_dec;
  logic            restore_act;
  logic [PW-1:0]   snap_tos_q;
  logic [CW-1:0]   snap_count_q;

`ifdef RAS_CKPT_EN
  logic [PW-1:0]   snap_tos;
  logic [CW-1:0]   snap_count;

  assign restore_act  = restore_i;
  assign snap_tos_q   = snap_tos;
  assign snap_count_q = snap_count;

  // Snapshot captures the post-update pointer; flush clears it outright.
  // With ckpt and restore together, tos_nxt/count_nxt already hold the
  // restored values, so the re-capture falls out naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_tos   <= '0;
      snap_count <= '0;
    end else if (flush_i) begin
      snap_tos   <= '0;
      snap_count <= '0;
    end else if (ckpt_i) begin
      snap_tos   <= tos_nxt;
      snap_count <= count_nxt;
    end
  end
`else
  // Ports kept for interface stability; nothing consumes them.
  logic unused_ckpt_inputs;
  assign unused_ckpt_inputs = ckpt_i | restore_i;
  assign restore_act        = 1'b0;
  assign snap_tos_q         = '0;
  assign snap_count_q       = '0;
`endif

  // Wrap by explicit compare so non-power-of-two depths work.
  assign tos_inc = (tos == LAST_IDX) ? '0 : tos + 1'b1;
  assign tos_dec = (tos == '0) ? LAST_IDX : tos - 1'b1;

  // Next-state selection: flush > restore > push/pop.
  always_comb begin
    tos_nxt   = tos;
    count_nxt = count;
    ovf_nxt   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = tos;
    if (flush_i) begin
      tos_nxt   = '0;
      count_nxt = '0;
    end else if (restore_act) begin
      tos_nxt   = snap_tos_q;
      count_nxt = snap_count_q;
    end else if (push_i && pop_i && (count != '0)) begin
      // Tail call: replace the top in place.
      wr_en = 1'b1;
    end else if (push_i) begin
      // Plain push (also the push+pop-on-empty case).
      tos_nxt = tos_inc;
      wr_en   = 1'b1;
      wr_idx  = tos_inc;
      if (count == FULL_CNT) begin
        ovf_nxt = 1'b1;
      end else begin
        count_nxt = count + 1'b1;
      end
    end else if (pop_i && (count != '0)) begin
      tos_nxt   = tos_dec;
      count_nxt = count - 1'b1;
    end
  end

  // Pointer, count and overflow pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      tos   <= tos_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Entry storage; contents cleared on reset so no stale address survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (wr_en) begin
      entries[wr_idx] <= addr_i;
    end
  end

  // Zero-latency read of the top entry, masked to zero when empty.
  always_comb begin
    top_o       = (count != '0) ? entries[tos] : '0;
    top_valid_o = (count != '0);
    count_o     = count;
    ovf_o       = ovf;
  end

endmodule
`default_nettype wire

// File: tb/tb_return_addr_stack_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : tb_return_addr_stack_ckpt
// Brief    : Directed self-checking bench for return_addr_stack_ckpt
//            (DEPTH=2, XLEN=32). Expected outputs are queued as each step is
//            driven and compared after the following clock edge.
//            Checkpoint expectations follow RAS_CKPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_return_addr_stack_ckpt;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            push_i = 1'b0;
  logic            pop_i = 1'b0;
  logic            ckpt_i = 1'b0;
  logic            restore_i = 1'b0;
  logic [XLEN-1:0] addr_i = '0;
  logic [XLEN-1:0] top_o;
  logic            top_valid_o;
  logic [CW-1:0]   count_o;
  logic            ovf_o;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] top;
    logic            valid;
    logic [CW-1:0]   cnt;
    logic            ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  return_addr_stack_ckpt #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .addr_i      (addr_i),
    .top_o       (top_o),
    .top_valid_o (top_valid_o),
    .count_o     (count_o),
    .ovf_o       (ovf_o),
    .ckpt_i      (ckpt_i),
    .restore_i   (restore_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [XLEN-1:0] etop, input logic ev,
                            input int ecnt, input logic eovf);
    exp_t e;
    e.tag   = tag;
    e.top   = etop;
    e.valid = ev;
    e.cnt   = CW'(ecnt);
    e.ovf   = eovf;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".top"},   top_o,                 e.top);
    chk({e.tag, ".valid"}, XLEN'(top_valid_o),    XLEN'(e.valid));
    chk({e.tag, ".count"}, XLEN'(count_o),        XLEN'(e.cnt));
    chk({e.tag, ".ovf"},   XLEN'(ovf_o),          XLEN'(e.ovf));
  endtask

  // One clock of stimulus; outputs are checked 1ns after the edge.
  task automatic step(input string tag, input logic fl, input logic pu, input logic po,
                      input logic ck, input logic rs, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] etop, input logic ev, input int ecnt,
                      input logic eovf);
    flush_i   = fl;
    push_i    = pu;
    pop_i     = po;
    ckpt_i    = ck;
    restore_i = rs;
    addr_i    = a;
    expect_out(tag, etop, ev, ecnt, eovf);
    @(posedge clk_i);
    #1;
    flush_i   = 1'b0;
    push_i    = 1'b0;
    pop_i     = 1'b0;
    ckpt_i    = 1'b0;
    restore_i = 1'b0;
    addr_i    = '0;
    compare_out();
  endtask

  initial begin
    // Reset state, checked between edges while reset is held.
    #12;
    expect_out("reset", 32'h0, 1'b0, 0, 1'b0);
    compare_out();
    rst_ni = 1'b1;

    // Overflow at DEPTH=2: 0x100 is lost.
    //    tag         fl pu po ck rs addr        top        v  cnt ovf
    step("ovf.p1",    0, 1, 0, 0, 0, 32'h100,    32'h100,   1, 1,  0);
    step("ovf.p2",    0, 1, 0, 0, 0, 32'h200,    32'h200,   1, 2,  0);
    step("ovf.p3",    0, 1, 0, 0, 0, 32'h300,    32'h300,   1, 2,  1);
    step("ovf.pop1",  0, 0, 1, 0, 0, 32'h0,      32'h200,   1, 1,  0);
    step("ovf.pop2",  0, 0, 1, 0, 0, 32'h0,      32'h0,     0, 0,  0);

    // Underflow is ignored.
    step("unf.pop1",  0, 0, 1, 0, 0, 32'h0,      32'h0,     0, 0,  0);
    step("unf.pop2",  0, 0, 1, 0, 0, 32'h0,      32'h0,     0, 0,  0);
    step("unf.pop3",  0, 0, 1, 0, 0, 32'h0,      32'h0,     0, 0,  0);
    step("unf.push",  0, 1, 0, 0, 0, 32'h44,     32'h44,    1, 1,  0);

    // Simultaneous push/pop.
    step("pp.flush",  1, 0, 0, 0, 0, 32'h0,      32'h0,     0, 0,  0);
    step("pp.p10",    0, 1, 0, 0, 0, 32'h10,     32'h10,    1, 1,  0);
    step("pp.p20",    0, 1, 0, 0, 0, 32'h20,     32'h20,    1, 2,  0);
    step("pp.pp30",   0, 1, 1, 0, 0, 32'h30,     32'h30,    1, 2,  0);
    step("pp.pop",    0, 0, 1, 0, 0, 32'h0,      32'h10,    1, 1,  0);
    step("pp.flush2", 1, 0, 0, 0, 0, 32'h0,      32'h0,     0, 0,  0);
    step("pp.empty",  0, 1, 1, 0, 0, 32'h50,     32'h50,    1, 1,  0);

    // Flush beats push in the same cycle.
    step("fl.p11",    0, 1, 0, 0, 0, 32'h11,     32'h11,    1, 2,  0);
    step("fl.fpush",  1, 1, 0, 0, 0, 32'h99,     32'h0,     0, 0,  0);
    step("fl.p60",    0, 1, 0, 0, 0, 32'h60,     32'h60,    1, 1,  0);

    // Checkpoint / restore.
    step("ck.flush",  1, 0, 0, 0, 0, 32'h0,      32'h0,     0, 0,  0);
    step("ck.pA0",    0, 1, 0, 0, 0, 32'hA0,     32'hA0,    1, 1,  0);
    step("ck.ckpt",   0, 0, 0, 1, 0, 32'h0,      32'hA0,    1, 1,  0);
    step("ck.pB0",    0, 1, 0, 0, 0, 32'hB0,     32'hB0,    1, 2,  0);
    step("ck.pop1",   0, 0, 1, 0, 0, 32'h0,      32'hA0,    1, 1,  0);
    step("ck.pop2",   0, 0, 1, 0, 0, 32'h0,      32'h0,     0, 0,  0);
`ifdef RAS_CKPT_EN
    step("ck.rest",   0, 0, 0, 0, 1, 32'h0,      32'hA0,    1, 1,  0);
    step("ck.pC0",    0, 1, 0, 0, 0, 32'hC0,     32'hC0,    1, 2,  0);
    step("ck.rstck",  0, 0, 0, 1, 1, 32'h0,      32'hA0,    1, 1,  0);
    step("ck.pop3",   0, 0, 1, 0, 0, 32'h0,      32'h0,     0, 0,  0);
    step("ck.rest2",  0, 0, 0, 0, 1, 32'h0,      32'hA0,    1, 1,  0);
`else
    step("ck.rest",   0, 0, 0, 0, 1, 32'h0,      32'h0,     0, 0,  0);
    step("ck.pC0",    0, 1, 0, 0, 0, 32'hC0,     32'hC0,    1, 1,  0);
    step("ck.rstck",  0, 1, 0, 1, 1, 32'hD0,     32'hD0,    1, 2,  0);
    step("ck.pop3",   0, 0, 1, 0, 0, 32'h0,      32'hC0,    1, 1,  0);
    step("ck.rest2",  0, 0, 0, 0, 1, 32'h0,      32'hC0,    1, 1,  0);
`endif

    // Asynchronous reset between edges while full.
    step("rs.flush",  1, 0, 0, 0, 0, 32'h0,      32'h0,     0, 0,  0);
    step("rs.p71",    0, 1, 0, 0, 0, 32'h71,     32'h71,    1, 1,  0);
    step("rs.p72",    0, 1, 0, 0, 0, 32'h72,     32'h72,    1, 2,  0);
    #2;
    rst_ni = 1'b0;
    #1;
    expect_out("rs.async", 32'h0, 1'b0, 0, 1'b0);
    compare_out();
    #1;
    rst_ni = 1'b1;
    step("rs.p70",    0, 1, 0, 0, 0, 32'h70,     32'h70,    1, 1,  0);

    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $error("FAIL scoreboard.drain: observed %0d left expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
